// File: rtl/router_controller.sv
// Router control FSM: accepts a 4-word packet, drives datapath loads, routes or drops it.
// Optional saturating drop counter output enabled by defining ROUTER_DROP_COUNT_EN.
module router_controller #(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SIZE-1:0] in_word,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SIZE-1:0] destnation,
    output logic [SIZE-1:0] data,
    output logic [SIZE:0]   checkSum,
    output logic            enableDes,
    output logic            enableData,
    output logic            enableCheck,
    output logic            enablePort1,
    output logic            enablePort2,
    input  logic            errorData,
    input  logic            desPort,
    input  logic            port1_ready,
    input  logic            port2_ready,
    output logic            port1_valid,
    output logic            port2_valid,
    output logic            pkt_drop,
`ifdef ROUTER_DROP_COUNT_EN
    output logic [7:0]      drop_count,
`endif
    output logic            busy
);

    localparam bit          HAS_TIMEOUT = (TIMEOUT != 0);
    localparam logic [15:0] WAIT_LAST   = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_DEST,
        S_DATA,
        S_CHK_LO,
        S_CHK_HI,
        S_EVAL,
        S_WAIT_PORT
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [SIZE-1:0] chkLo;
    logic [15:0]     waitCnt;
    logic            tgtPort;

    logic inputPhase;
    logic accept;
    logic tgtReady;
    logic desLoad;
    logic dataLoad;
    logic chkLoLoad;
    logic chkLoad;
    logic p1Load;
    logic p2Load;
    logic dropReq;
    logic cntClr;
    logic cntInc;
    logic tgtLatch;

    assign inputPhase = (state == S_DEST) || (state == S_DATA) ||
                        (state == S_CHK_LO) || (state == S_CHK_HI);
    assign in_ready   = inputPhase && reset;
    assign accept     = in_valid && in_ready;
    assign tgtReady   = tgtPort ? port2_ready : port1_ready;
    assign busy       = (state != S_DEST);

    assign destnation = in_word;
    assign data       = in_word;
    assign checkSum   = {in_word[0], chkLo};

    always_comb begin
        nextState = state;
        desLoad   = 1'b0;
        dataLoad  = 1'b0;
        chkLoLoad = 1'b0;
        chkLoad   = 1'b0;
        p1Load    = 1'b0;
        p2Load    = 1'b0;
        dropReq   = 1'b0;
        cntClr    = 1'b0;
        cntInc    = 1'b0;
        tgtLatch  = 1'b0;
        case (state)
            S_DEST: begin
                if (accept) begin
                    desLoad   = 1'b1;
                    nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    dataLoad  = 1'b1;
                    nextState = S_CHK_LO;
                end
            end
            S_CHK_LO: begin
                if (accept) begin
                    chkLoLoad = 1'b1;
                    nextState = S_CHK_HI;
                end
            end
            S_CHK_HI: begin
                if (accept) begin
                    chkLoad   = 1'b1;
                    nextState = S_EVAL;
                end
            end
            S_EVAL: begin
                // Decide on the live comparator; remember the port for any wait that follows.
                tgtLatch = 1'b1;
                if (!errorData) begin
                    dropReq   = 1'b1;
                    nextState = S_DEST;
                end else if (desPort ? port2_ready : port1_ready) begin
                    p2Load    = desPort;
                    p1Load    = !desPort;
                    nextState = S_DEST;
                end else begin
                    cntClr    = 1'b1;
                    nextState = S_WAIT_PORT;
                end
            end
            S_WAIT_PORT: begin
                if (tgtReady) begin
                    p2Load    = tgtPort;
                    p1Load    = !tgtPort;
                    nextState = S_DEST;
                end else if (HAS_TIMEOUT && (waitCnt == WAIT_LAST)) begin
                    dropReq   = 1'b1;
                    nextState = S_DEST;
                end else begin
                    cntInc = 1'b1;
                end
            end
            default: nextState = S_DEST;
        endcase
    end

    assign enableDes   = desLoad && reset;
    assign enableData  = dataLoad && reset;
    assign enableCheck = chkLoad && reset;
    assign enablePort1 = p1Load && reset;
    assign enablePort2 = p2Load && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_DEST;
            chkLo       <= '0;
            waitCnt     <= '0;
            tgtPort     <= 1'b0;
            port1_valid <= 1'b0;
            port2_valid <= 1'b0;
            pkt_drop    <= 1'b0;
        end else begin
            state <= nextState;
            if (chkLoLoad) begin
                chkLo <= in_word;
            end
            if (cntClr) begin
                waitCnt <= '0;
            end else if (cntInc) begin
                waitCnt <= waitCnt + 16'd1;
            end
            if (tgtLatch) begin
                tgtPort <= desPort;
            end
            port1_valid <= enablePort1;
            port2_valid <= enablePort2;
            pkt_drop    <= dropReq;
        end
    end

`ifdef ROUTER_DROP_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (dropReq && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
